// File: rtl/mul_arbiter_if.sv
// Request, result and multiplier-side signals of the two-port multiplier arbiter.
// Index k of each 2-wide field belongs to requester k.
interface mul_arbiter_if;
  logic [1:0]       req_valid_i;
  logic [1:0][63:0] req_opr_a_i;
  logic [1:0][63:0] req_opr_b_i;
  logic [1:0][3:0]  req_func_i;
  logic [1:0]       req_word_i;
  logic [1:0]       req_ready_o;
  logic [1:0]       res_valid_o;
  logic [63:0]      res_data_o;
  logic [1:0]       res_ready_i;
  logic             mul_valid_o;
  logic [63:0]      mul_opr_a_o;
  logic [63:0]      mul_opr_b_o;
  logic [3:0]       mul_func_o;
  logic             mul_word_o;
  logic             mul_ready_i;
  logic [63:0]      mul_res_i;
  logic             mul_res_valid_i;
  logic             mul_ready_o;
  logic             flush_i;
  logic             flush_o;

  modport slave (
    input  req_valid_i, req_opr_a_i, req_opr_b_i, req_func_i, req_word_i,
    input  res_ready_i, mul_ready_i, mul_res_i, mul_res_valid_i, flush_i,
    output req_ready_o, res_valid_o, res_data_o,
    output mul_valid_o, mul_opr_a_o, mul_opr_b_o, mul_func_o, mul_word_o,
    output mul_ready_o, flush_o
  );

  modport master (
    output req_valid_i, req_opr_a_i, req_opr_b_i, req_func_i, req_word_i,
    output res_ready_i, mul_ready_i, mul_res_i, mul_res_valid_i, flush_i,
    input  req_ready_o, res_valid_o, res_data_o,
    input  mul_valid_o, mul_opr_a_o, mul_opr_b_o, mul_func_o, mul_word_o,
    input  mul_ready_o, flush_o
  );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one multi-cycle multiplier between two requesters,
// with a one-entry result buffer that frees the multiplier as soon as it finishes.
module mul_arbiter (
  input  logic         clk,
  input  logic         resetn,
  mul_arbiter_if.slave bus
);

  typedef enum logic {
    T_IDLE = 1'b0,
    T_BUSY = 1'b1
  } state_t;

  state_t      state_r;
  state_t      state_nx_s;
  logic        owner_r;
  logic        prio_r;
  logic        buf_valid_r;
  logic        buf_owner_r;
  logic [63:0] buf_data_r;

  logic        any_req_s;
  logic        winner_s;
  logic        can_issue_s;
  logic        grant_s;
  logic        capture_s;
  logic        drain_s;
  logic [1:0]  res_valid_s;

  // Winner selection and the combinational grant/capture/drain events.
  always_comb begin
    any_req_s = |bus.req_valid_i;
    if (&bus.req_valid_i) begin
      winner_s = prio_r;
    end else begin
      winner_s = bus.req_valid_i[1];
    end
    can_issue_s    = (state_r == T_IDLE) & bus.mul_ready_i & ~bus.flush_i;
    grant_s        = can_issue_s & any_req_s;
    // A result outside T_BUSY is a protocol error and is never captured.
    capture_s      = bus.mul_res_valid_i & ~buf_valid_r & ~bus.flush_i & (state_r == T_BUSY);
    res_valid_s[0] = buf_valid_r & ~buf_owner_r & ~bus.flush_i;
    res_valid_s[1] = buf_valid_r &  buf_owner_r & ~bus.flush_i;
    drain_s        = |(res_valid_s & bus.res_ready_i);
  end

  // Issue-side outputs muxed from the winner, zero when nothing is granted.
  always_comb begin
    bus.req_ready_o = grant_s ? (winner_s ? 2'b10 : 2'b01) : 2'b00;
    bus.mul_valid_o = grant_s;
    bus.mul_opr_a_o = grant_s ? bus.req_opr_a_i[winner_s] : 64'd0;
    bus.mul_opr_b_o = grant_s ? bus.req_opr_b_i[winner_s] : 64'd0;
    bus.mul_func_o  = grant_s ? bus.req_func_i[winner_s]  : 4'd0;
    bus.mul_word_o  = grant_s ? bus.req_word_i[winner_s]  : 1'b0;
  end

  // Result-side outputs.
  always_comb begin
    bus.res_valid_o = res_valid_s;
    bus.res_data_o  = buf_data_r;
    bus.mul_ready_o = ~buf_valid_r;
    bus.flush_o     = bus.flush_i;
  end

  // Tracker next state; flush already suppresses grant and capture.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      T_IDLE: begin
        if (grant_s) begin
          state_nx_s = T_BUSY;
        end else begin
          state_nx_s = T_IDLE;
        end
      end
      T_BUSY: begin
        if (bus.flush_i || capture_s) begin
          state_nx_s = T_IDLE;
        end else begin
          state_nx_s = T_BUSY;
        end
      end
      default: state_nx_s = T_IDLE;
    endcase
  end

  // Tracker state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= T_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Owner of the in-flight op and round-robin pointer, both updated on grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_r <= 1'b0;
      prio_r  <= 1'b0;
    end else if (grant_s) begin
      owner_r <= winner_s;
      prio_r  <= ~winner_s;
    end else begin
      owner_r <= owner_r;
      prio_r  <= prio_r;
    end
  end

  // One-entry result buffer; capture and drain never coincide because
  // capture requires the buffer to be empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_valid_r <= 1'b0;
      buf_owner_r <= 1'b0;
      buf_data_r  <= 64'd0;
    end else if (bus.flush_i) begin
      buf_valid_r <= 1'b0;
    end else if (capture_s) begin
      buf_valid_r <= 1'b1;
      buf_owner_r <= owner_r;
      buf_data_r  <= bus.mul_res_i;
    end else if (drain_s) begin
      buf_valid_r <= 1'b0;
    end else begin
      buf_valid_r <= buf_valid_r;
    end
  end

endmodule
